// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up initialization sequencer.
// Walks the JEDEC reset/CKE/MRS/ZQCL sequence using a single down-counter for
// every timed wait, then parks in DONE with ready asserted until restarted.
// All outputs come straight from flops that are loaded from the decode of the
// next state, so outputs and state change on the same edge.
module ddr3_init_sequencer #(
    parameter int              ADDR_W   = 14,
    parameter int              BA_W     = 3,
    parameter int              T_RESET  = 125000,
    parameter int              T_CKE    = 312500,
    parameter int              T_XPR    = 76,
    parameter int              T_MRD    = 6,
    parameter int              T_MOD    = 30,
    parameter int              T_ZQINIT = 1024,
    parameter logic [ADDR_W-1:0] MR0    = ADDR_W'('h0910),
    parameter logic [ADDR_W-1:0] MR1    = ADDR_W'('h0010),
    parameter logic [ADDR_W-1:0] MR2    = ADDR_W'('h0000),
    parameter logic [ADDR_W-1:0] MR3    = ADDR_W'('h0000),
    parameter int              FAST_SIM = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    output logic              ready,
    output logic              busy,
    output logic              csbar,
    output logic              rasbar,
    output logic              casbar,
    output logic              webar,
    output logic [BA_W-1:0]   ba,
    output logic [ADDR_W-1:0] a,
    output logic              cke,
    output logic              resetbar,
    output logic              odt,
    output logic              ts_con
);

    // Long power-up waits collapse to a short fixed value for fast simulation.
    localparam int T_RST_E = (FAST_SIM != 0) ? 16 : T_RESET;
    localparam int T_CKE_E = (FAST_SIM != 0) ? 16 : T_CKE;

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_RST_E, T_CKE_E), max2(T_XPR, T_MRD)),
                                max2(T_MOD, T_ZQINIT));
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_MRS  = 4'b0000;
    localparam logic [3:0] CMD_ZQCL = 4'b0110;

    // ZQCL long calibration: only A10 set.
    localparam logic [ADDR_W-1:0] ZQ_ADDR = ADDR_W'(32'h0000_0400);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_LOW, S_CKE_WAIT, S_XPR_WAIT,
        S_MRS2, S_MRS3, S_MRS1, S_MRS0,
        S_MRD_WAIT, S_MOD_WAIT, S_ZQCL, S_ZQ_WAIT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    // Which MRS preceded the shared MRD wait, so the wait knows where to go next.
    logic [1:0]          mr_q, mr_d;

    logic [3:0]          cmd_q, cmd_d;
    logic [BA_W-1:0]     ba_q, ba_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic                cke_q, cke_d;
    logic                resetbar_q, resetbar_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                odt_q, ts_con_q;

    logic                expired;
    assign expired = (cnt_q == '0);

    // Next-state and wait-counter sequencing.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        mr_d    = mr_q;
        if (!expired) cnt_d = cnt_q - CNT_W'(1);
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (init) begin
                    state_d = S_RST_LOW;
                    cnt_d   = CNT_W'(T_RST_E - 1);
                end
            end
            S_RST_LOW: if (expired) begin
                state_d = S_CKE_WAIT;
                cnt_d   = CNT_W'(T_CKE_E - 1);
            end
            S_CKE_WAIT: if (expired) begin
                state_d = S_XPR_WAIT;
                cnt_d   = CNT_W'(T_XPR - 1);
            end
            S_XPR_WAIT: if (expired) state_d = S_MRS2;
            S_MRS2, S_MRS3, S_MRS1: begin
                state_d = S_MRD_WAIT;
                cnt_d   = CNT_W'(T_MRD - 1);
                mr_d    = (state_q == S_MRS2) ? 2'd2 : (state_q == S_MRS3) ? 2'd3 : 2'd1;
            end
            S_MRD_WAIT: if (expired) begin
                unique case (mr_q)
                    2'd2:    state_d = S_MRS3;
                    2'd3:    state_d = S_MRS1;
                    default: state_d = S_MRS0;
                endcase
            end
            S_MRS0: begin
                state_d = S_MOD_WAIT;
                cnt_d   = CNT_W'(T_MOD - 1);
            end
            S_MOD_WAIT: if (expired) state_d = S_ZQCL;
            S_ZQCL: begin
                state_d = S_ZQ_WAIT;
                cnt_d   = CNT_W'(T_ZQINIT - 1);
            end
            S_ZQ_WAIT: if (expired) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode of the state being entered, registered below.
    always_comb begin
        cmd_d      = CMD_NOP;
        ba_d       = '0;
        a_d        = '0;
        cke_d      = 1'b1;
        resetbar_d = 1'b1;
        ready_d    = 1'b0;
        busy_d     = 1'b1;
        unique case (state_d)
            S_IDLE: begin
                cke_d      = 1'b0;
                resetbar_d = 1'b0;
                busy_d     = 1'b0;
            end
            S_RST_LOW: begin
                cke_d      = 1'b0;
                resetbar_d = 1'b0;
            end
            S_CKE_WAIT: cke_d = 1'b0;
            S_MRS2: begin cmd_d = CMD_MRS; ba_d = BA_W'(2'd2); a_d = MR2; end
            S_MRS3: begin cmd_d = CMD_MRS; ba_d = BA_W'(2'd3); a_d = MR3; end
            S_MRS1: begin cmd_d = CMD_MRS; ba_d = BA_W'(2'd1); a_d = MR1; end
            S_MRS0: begin cmd_d = CMD_MRS; ba_d = BA_W'(2'd0); a_d = MR0; end
            S_ZQCL: begin cmd_d = CMD_ZQCL; a_d = ZQ_ADDR; end
            S_DONE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    // State, counter and registered outputs; synchronous reset wins over init.
    always_ff @(posedge clk) begin
        // NOTE: only the control state and the outputs need a reset value; the
        // counter is reset too so a stale count can never leak into a new run.
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            mr_q       <= '0;
            cmd_q      <= CMD_NOP;
            ba_q       <= '0;
            a_q        <= '0;
            cke_q      <= 1'b0;
            resetbar_q <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            odt_q      <= 1'b0;
            ts_con_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mr_q       <= mr_d;
            cmd_q      <= cmd_d;
            ba_q       <= ba_d;
            a_q        <= a_d;
            cke_q      <= cke_d;
            resetbar_q <= resetbar_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            odt_q      <= 1'b0;
            ts_con_q   <= 1'b0;
        end
    end

    assign {csbar, rasbar, casbar, webar} = cmd_q;
    assign ba       = ba_q;
    assign a        = a_q;
    assign cke      = cke_q;
    assign resetbar = resetbar_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign odt      = odt_q;
    assign ts_con   = ts_con_q;

endmodule

// File: doc/ddr3_init_sequencer.md
DDR3_INIT_SEQUENCER -- requirements
Module: ddr3_init_sequencer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 14, row/MR address width.
REQ-002 SHALL provide parameter BA_W, default 3, bank address width (must be at least 2).
REQ-003 SHALL provide timing parameters, each in clk cycles and each at least 1:
- T_RESET, default 125000, resetbar low time.
- T_CKE, default 312500, resetbar high to CKE high.
- T_XPR, default 76.
- T_MRD, default 6.
- T_MOD, default 30.
- T_ZQINIT, default 1024.
REQ-004 SHALL provide parameters MR0 (default 'h0910), MR1 (default 'h0010), MR2 (default 'h0000) and MR3 (default 'h0000), each ADDR_W wide, as the mode-register payloads.
REQ-005 SHALL provide parameter FAST_SIM, default 0; when 1, T_RESET and T_CKE are each replaced by 16.
REQ-006 Ports, each as name, direction, width, meaning:
- clk  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- init  in  1  start/restart request, level-sampled.
- ready  out  1  initialization complete.
- busy  out  1  sequence in progress.
- csbar, rasbar, casbar, webar  out  1 each  DDR3 command bits.
- ba  out  BA_W  bank address.
- a  out  ADDR_W  address.
- cke  out  1  clock enable.
- resetbar  out  1  DRAM reset, active-low.
- odt  out  1  on-die termination.
- ts_con  out  1  DQ tristate control.

Function
REQ-007 All outputs SHALL be registered; internal state changes and output changes occur on the same edge.
REQ-008 The FSM SHALL have these states, with durations:
- IDLE
- RST_LOW (T_RESET cycles)
- CKE_WAIT (T_CKE)
- XPR_WAIT (T_XPR)
- MRS2, MRS3, MRS1, MRS0 (1 cycle each)
- MRD_WAIT (T_MRD, after MRS2, MRS3 and MRS1)
- MOD_WAIT (T_MOD, after MRS0)
- ZQCL (1 cycle)
- ZQ_WAIT (T_ZQINIT)
- DONE
REQ-009 In IDLE, init=1 at an edge SHALL enter RST_LOW with resetbar=0, cke=0 and busy=1.
REQ-010 State order SHALL be: RST_LOW, CKE_WAIT, XPR_WAIT, MRS2, MRD_WAIT, MRS3, MRD_WAIT, MRS1, MRD_WAIT, MRS0, MOD_WAIT, ZQCL, ZQ_WAIT, DONE.
REQ-011 Entering CKE_WAIT SHALL set resetbar=1; entering XPR_WAIT SHALL set cke=1 with a NOP command.
REQ-012 Command encodings {csbar,rasbar,casbar,webar} SHALL be: NOP=0111, MRS=0000, ZQCL=0110.
REQ-013 MRSn SHALL drive MRS with ba=n (zero-extended to BA_W) and a=MRn for exactly one cycle; the following wait state SHALL drive NOP.
REQ-014 ZQCL SHALL drive the ZQCL command with a[10]=1 and all other a bits 0, ba=0, for one cycle.
REQ-015 DONE SHALL drive NOP, ready=1 and busy=0, and SHALL hold indefinitely.
REQ-016 init=1 while in DONE SHALL restart at RST_LOW; ready drops on that same edge.
REQ-017 init SHALL be ignored in every state other than IDLE and DONE.
REQ-018 Latency from the init-sampling edge to ready=1 SHALL be T_RESET+T_CKE+T_XPR+3*T_MRD+T_MOD+T_ZQINIT+5 cycles.
REQ-019 The wait counter SHALL be sized to the largest effective timing parameter and SHALL NOT wrap within any state.
REQ-020 odt and ts_con SHALL be 0 at all times.

Reset
REQ-021 reset=1 SHALL, at the next edge, force IDLE with these values and hold them while reset=1:
- ready=0, busy=0
- cke=0, resetbar=0
- {csbar,rasbar,casbar,webar}=0111
- ba=0, a=0
- odt=0, ts_con=0
REQ-022 reset SHALL take priority over init and SHALL abort a sequence in any state.
REQ-023 After reset deasserts, init SHALL be required to start a new sequence.

Verification
REQ-024 All scenarios use parameters T_RESET=4, T_CKE=5, T_XPR=3, T_MRD=2, T_MOD=3, T_ZQINIT=6 and FAST_SIM=0, giving a latency of 32 cycles.
REQ-025 Scenario, full sequence: reset, then a 1-cycle init pulse -> resetbar low for 4 cycles, cke high 9 cycles after init, MRS commands with ba=2, 3, 1, 0 at cycles 12, 15, 18, 21, ZQCL at cycle 25 with a[10]=1, ready=1 at cycle 32.
REQ-026 Scenario, MR payloads: MR0='h1234 and MR1='h0ABC -> a equals each value only during its MRS cycle; NOP on all other cycles.
REQ-027 Scenario, init ignored: init held high throughout the sequence -> no restart and ready still at cycle 32; init then kept high in DONE -> restart, ready=0 on the next edge.
REQ-028 Scenario, reset abort: reset at cycle 16 (MRS3 wait) -> all REQ-021 values on the next edge; no command until a new init.
REQ-029 Scenario, FAST_SIM: FAST_SIM=1 with default T_XPR, T_MRD, T_MOD and T_ZQINIT -> ready at 16+16+76+18+30+1024+5=1185 cycles.
